// File: rtl/fifo_pkg.sv
// Shared types for the async-FIFO read-side stream adapter.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;

  typedef logic [1:0] occ_t;

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream presented by the FIFO read adapter.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/rd_skid_buf2.sv
// Two-entry register FIFO; entry 0 is always the head, so the head only moves on pop.
module rd_skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output occ_t             occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] entry_reg [2];
  occ_t             occ_reg;

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      occ_reg     <= '0;
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
    end else if (clear) begin
      occ_reg <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ_reg == 2'd0) entry_reg[0] <= push_data;
          else                 entry_reg[1] <= push_data;
          occ_reg <= occ_reg + 2'd1;
        end
        2'b01: begin
          entry_reg[0] <= entry_reg[1];
          occ_reg      <= occ_reg - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever stays.
          if (occ_reg == 2'd1) begin
            entry_reg[0] <= push_data;
          end else begin
            entry_reg[0] <= entry_reg[1];
            entry_reg[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ       = occ_reg;
  assign head_data = entry_reg[0];

  no_capture_when_full: assert property (@(posedge rd_clk) disable iff (reset)
    !(push && !clear && occ_reg == 2'd2));

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the async FIFO with one-cycle read latency and re-presents words as a
// bubble-free valid/ready stream through a 2-entry buffer.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic               rd_clk,
  input  logic               reset,
  output logic               fifo_rd_en,
  input  logic               fifo_rd_empty,
  input  logic [WIDTH-1:0]   fifo_data_out,
  input  logic               flush,
  fifo_rd_stream_if.master   m,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               busy
);

  occ_t             occ;
  occ_t             occ_next_free;
  logic [2:0]       credit_used;
  logic [WIDTH-1:0] head_data;
  logic             pop;
  logic             push;
  logic             inflight_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] word_cnt_reg;

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = head_data;
  assign pop       = m.m_valid & m.m_ready;

  // A slot freed by this cycle's handshake can already be claimed by a new read.
  assign occ_next_free = occ - {1'b0, pop};
  assign credit_used   = {1'b0, occ_next_free} + {2'b00, inflight_reg};
  assign fifo_rd_en    = !reset && !flush && !fifo_rd_empty && (credit_used < 3'd2);

  assign push = inflight_reg && !flush && (state_reg == RUN);

  rd_skid_buf2 #(.WIDTH(WIDTH)) u_buf (
    .rd_clk    (rd_clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      inflight_reg <= 1'b0;
      state_reg    <= RUN;
      word_cnt_reg <= '0;
    end else begin
      inflight_reg <= fifo_rd_en;
      word_cnt_reg <= word_cnt_reg + CNT_W'(pop);
      unique case (state_reg)
        RUN:     if (flush) state_reg <= DRAIN;
        DRAIN:   if (!flush) state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

  assign word_cnt = word_cnt_reg;
  assign busy     = (occ != 2'd0) | inflight_reg;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream against a queue-based model of the FIFO and buffer.
module tb_fifo_rd_stream;

  localparam int CNT_W = 4;

  logic             rd_clk = 1'b0;
  logic             reset;
  logic             fifo_rd_en;
  logic             fifo_rd_empty;
  logic [7:0]       fifo_data_out;
  logic             flush;
  logic [CNT_W-1:0] word_cnt;
  logic             busy;

  fifo_rd_stream_if #(.WIDTH(8)) m_if ();

  fifo_rd_stream #(.WIDTH(8), .CNT_W(CNT_W)) dut (
    .rd_clk        (rd_clk),
    .reset         (reset),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_data_out (fifo_data_out),
    .flush         (flush),
    .m             (m_if),
    .word_cnt      (word_cnt),
    .busy          (busy)
  );

  always #5 rd_clk = ~rd_clk;

  logic [7:0] src_q [$];
  logic [7:0] buf_q [$];
  bit         inflight_m;
  int         cnt_m;
  bit         data_zero;
  bit         model_known;
  logic [7:0] arriving;
  int         checks;
  int         errors;
  bit         last_hs;
  bit         last_rd_en;
  bit         last_valid;
  int         beat_no;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic rdy);
    bit exp_valid;
    bit exp_rd_en;
    bit hs;
    bit obs_rd_en;
    int used;
    @(negedge rd_clk);
    reset          = rst;
    flush          = fl;
    m_if.m_ready   = rdy;
    fifo_rd_empty  = (src_q.size() == 0);
    #1;
    exp_valid = (buf_q.size() != 0);
    hs        = exp_valid && rdy;
    used      = buf_q.size() - (hs ? 1 : 0) + (inflight_m ? 1 : 0);
    exp_rd_en = !rst && !fl && !fifo_rd_empty && (used < 2);
    obs_rd_en = fifo_rd_en;
    if (model_known) begin
      check_val("m_valid", 32'(m_if.m_valid), 32'(exp_valid));
      if (exp_valid)
        check_val("m_data", 32'(m_if.m_data), 32'(buf_q[0]));
      else if (data_zero)
        check_val("m_data_rst", 32'(m_if.m_data), 32'd0);
      check_val("rd_en", 32'(fifo_rd_en), 32'(exp_rd_en));
      check_val("busy", 32'(busy), 32'(exp_valid || inflight_m));
      check_val("word_cnt", 32'(word_cnt), 32'(cnt_m));
      if (hs) begin
        $display("beat %0d data=%02h word_cnt=%0d", beat_no, buf_q[0], cnt_m);
        beat_no++;
      end
    end
    last_hs    = hs;
    last_rd_en = obs_rd_en;
    last_valid = m_if.m_valid;
    @(posedge rd_clk);
    if (rst) begin
      buf_q.delete();
      inflight_m  = 1'b0;
      cnt_m       = 0;
      data_zero   = 1'b1;
      model_known = 1'b1;
    end else begin
      if (hs) begin
        void'(buf_q.pop_front());
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
      end
      if (fl) begin
        buf_q.delete();
      end else if (inflight_m) begin
        buf_q.push_back(arriving);
        data_zero = 1'b0;
      end
      inflight_m = exp_rd_en;
    end
    #1;
    if (obs_rd_en && src_q.size() != 0) arriving = src_q.pop_front();
    else arriving = 8'($urandom);
    fifo_data_out = arriving;
  endtask

  task automatic fill_seq(input int n);
    for (int i = 1; i <= n; i++) src_q.push_back(8'(i));
  endtask

  initial begin
    int first_valid;
    int first_hs;
    int last_hs_k;
    int beats;
    int rd_cnt;
    reset         = 1'b1;
    flush         = 1'b0;
    m_if.m_ready  = 1'b0;
    fifo_rd_empty = 1'b1;
    fifo_data_out = 8'h00;
    arriving      = 8'h00;
    checks        = 0;
    errors        = 0;
    beat_no       = 0;
    model_known   = 1'b0;
    data_zero     = 1'b1;
    inflight_m    = 1'b0;
    cnt_m         = 0;

    // Reset held with a non-empty FIFO
    fill_seq(16);
    repeat (3) cycle(1'b1, 1'b0, 1'b1);
    check_val("t1_rd_en", 32'(fifo_rd_en), 32'd0);
    check_val("t1_valid", 32'(m_if.m_valid), 32'd0);
    check_val("t1_cnt", 32'(word_cnt), 32'd0);
    check_val("t1_data", 32'(m_if.m_data), 32'd0);
    check_val("t1_busy", 32'(busy), 32'd0);

    // Release and stream 16 words at full rate
    first_valid = -1;
    first_hs    = -1;
    last_hs_k   = -1;
    beats       = 0;
    for (int k = 0; k < 22; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (k == 0) check_val("t1_rd_en_c1", 32'(last_rd_en), 32'd1);
      if (last_valid && first_valid < 0) first_valid = k;
      if (last_hs) begin
        beats++;
        if (first_hs < 0) first_hs = k;
        last_hs_k = k;
      end
    end
    check_val("t1_first_valid", 32'(first_valid), 32'd2);
    check_val("t2_beats", 32'(beats), 32'd16);
    check_val("t2_span", 32'(last_hs_k - first_hs + 1), 32'd16);

    // Sink stalled: exactly two reads issued, head held
    cycle(1'b1, 1'b0, 1'b1);
    fill_seq(16);
    rd_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      rd_cnt += last_rd_en ? 1 : 0;
    end
    check_val("t3_rd_en_cnt", 32'(rd_cnt), 32'd2);
    check_val("t3_head", 32'(m_if.m_data), 32'h01);
    repeat (22) cycle(1'b0, 1'b0, 1'b1);

    // Alternating ready
    for (int i = 0; i < 32; i++) src_q.push_back(8'($urandom));
    for (int k = 0; k < 80; k++) cycle(1'b0, 1'b0, (k % 2) == 0);

    // Flush while streaming (occ=1, inflight=1) and while full (occ=2)
    fill_seq(40);
    repeat (4) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check_val("t5_valid_after_flush", 32'(last_valid), 32'd0);
    repeat (6) cycle(1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_val("t5_valid_after_flush2", 32'(last_valid), 32'd0);
    repeat (40) cycle(1'b0, 1'b0, 1'b1);

    // Random traffic with sporadic flush and reset
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) != 0 && src_q.size() < 8) src_q.push_back(8'($urandom));
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
            ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
